// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch types and constants
package cpu_pkg;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with push/pop/clear and occupancy count
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue is accepted only when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !clear));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch sequencer: imem req/gnt/rvalid to in-order valid/ready queue
// Optional FETCH_MISALIGN_EN: misaligned redirects halt fetch and raise o_fetchFault.
module instr_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clock,
  input  logic        i_resetn,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemGnt,
  input  logic        i_imemRvalid,
  input  logic [31:0] i_imemData,
  output logic        o_instrValid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instrPC,
  input  logic        i_instrReady,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPC
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        o_fetchFault
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state, state_n;
  logic [31:0]   pc, pc_n;
  logic [CW-1:0] discard, discard_n;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] q_count;
  logic [CW-1:0] stale_n;
  logic [CW:0]   credits_used;
  logic          accept, take, drop, misalign;
  logic          q_empty, q_full, tag_empty, tag_full;
  logic          unused_full;
  logic [31:0]   tag_head;
  fetch_entry_t  q_head, q_push_data;

  assign accept       = o_imemReq && i_imemGnt;
  // Unsolicited responses (no tag outstanding) are never consumed
  assign take         = i_imemRvalid && (discard == '0) && !tag_empty;
  assign drop         = i_imemRvalid && (discard != '0);
  assign credits_used = {1'b0, outstanding} + {1'b0, q_count};
  assign stale_n      = discard + outstanding + CW'(accept) - CW'(i_imemRvalid);
  assign unused_full  = q_full ^ tag_full;

  assign o_imemReq  = (state == RUN) && !i_redirect && !tag_full &&
                      (credits_used < (CW+1)'(DEPTH));
  assign o_imemAddr = pc;

`ifdef FETCH_MISALIGN_EN
  assign misalign = (i_redirectPC[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard - CW'(drop);
    if (accept) pc_n = pc + INSTR_BYTES;
    case (state)
      IDLE:    state_n = RUN;
      FLUSH:   if (discard_n == '0) state_n = RUN;
      default: ;
    endcase
    // Every response still in flight at a redirect belongs to the old stream
    if (i_redirect) begin
      pc_n      = i_redirectPC & ~32'h3;
      discard_n = stale_n;
      if (misalign)              state_n = HALT;
      else if (stale_n != '0)    state_n = FLUSH;
      else                       state_n = RUN;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      discard <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      discard <= discard_n;
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn)       o_fetchFault <= 1'b0;
    else if (i_redirect) o_fetchFault <= misalign;
  end
`endif

  // Tag FIFO occupancy is the outstanding-request count
  fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_tag_fifo (
    .clk       (i_clock),
    .rst_n     (i_resetn),
    .clear     (i_redirect),
    .push      (accept),
    .push_data (pc),
    .pop       (take && !i_redirect),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  assign q_push_data = '{pc: tag_head, instr: i_imemData};

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_instr_q (
    .clk       (i_clock),
    .rst_n     (i_resetn),
    .clear     (i_redirect),
    .push      (take && !i_redirect),
    .push_data (q_push_data),
    .pop       (i_instrReady && !i_redirect),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign o_instrValid = !q_empty;
  assign o_instr      = q_empty ? 32'h0 : q_head.instr;
  assign o_instrPC    = q_empty ? 32'h0 : q_head.pc;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - randomized bench with epoch-tagged memory model for instr_fetch_ctrl
module tb_instr_fetch_ctrl;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, rvalid, ivalid, ready, redirect;
  logic [31:0] addr, rdata, instr, ipc, redirect_pc;
`ifdef FETCH_MISALIGN_EN
  logic        fault;
`endif

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clock      (clk),
    .i_resetn     (rst_n),
    .o_imemReq    (req),
    .o_imemAddr   (addr),
    .i_imemGnt    (gnt),
    .i_imemRvalid (rvalid),
    .i_imemData   (rdata),
    .o_instrValid (ivalid),
    .o_instr      (instr),
    .o_instrPC    (ipc),
    .i_instrReady (ready),
    .i_redirect   (redirect),
    .i_redirectPC (redirect_pc)
`ifdef FETCH_MISALIGN_EN
    ,
    .o_fetchFault (fault)
`endif
  );

  typedef struct {logic [31:0] addr; int epoch; int gcyc;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;

  mreq_t       mem_q[$];
  ent_t        exp_q[$];
  logic [31:0] dl_pc[$];
  int          dl_cyc[$];
  logic [31:0] req_log[$];
  int          epoch, cyc, grants, valid_seen;
  logic [31:0] exp_addr;
  bit          halted, m_fault;
  bit          s_req, s_valid, s_fault;
  logic [31:0] s_pc;
  int          p_gnt, p_rv, p_rdy, p_redir;
  bit          force_redir;
  logic [31:0] force_pc;
  int          checks = 0;
  int          passes = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] pick_pc();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(3))
      0:       return 32'hFFFF_FFF8;
      1:       return {20'h0, r[11:2], 2'b00};
      2:       return {20'h0, r[11:0]};
      default: return {r[31:2], 2'b00};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic set_knobs(input int g, input int rv, input int rd, input int rr);
    p_gnt = g; p_rv = rv; p_rdy = rd; p_redir = rr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    gnt = 0; rvalid = 0; ready = 0; redirect = 0; redirect_pc = 0; rdata = 0;
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(ivalid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", ipc, 32'h0);
`ifdef FETCH_MISALIGN_EN
    chk("rst_fault", 32'(fault), 32'd0);
`endif
    mem_q.delete(); exp_q.delete(); dl_pc.delete(); dl_cyc.delete(); req_log.delete();
    epoch = 0; cyc = 0; grants = 0; valid_seen = 0;
    exp_addr = RESET_PC; halted = 0; m_fault = 0; force_redir = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(req), 32'd0);
    @(posedge clk);
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge
  task automatic cycle();
    int    stale, cur;
    bit    exp_req;
    mreq_t r;
    @(negedge clk);
    redirect    = force_redir || ($urandom_range(99) < p_redir);
    redirect_pc = force_redir ? force_pc : pick_pc();
    force_redir = 0;
    gnt         = ($urandom_range(99) < p_gnt);
    rvalid      = (mem_q.size() > 0) && (mem_q[0].gcyc < cyc) && ($urandom_range(99) < p_rv);
    rdata       = rvalid ? data_of(mem_q[0].addr) : $urandom;
    ready       = ($urandom_range(99) < p_rdy);
    #1;
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    cur     = mem_q.size() - stale;
    exp_req = !halted && (stale == 0) && (cur + exp_q.size() < DEPTH) && !redirect;
    chk("req", 32'(req), 32'(exp_req));
    if (exp_req) chk("addr", addr, exp_addr);
    chk("valid", 32'(ivalid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("head_pc", ipc, exp_q[0].pc);
      chk("head_instr", instr, exp_q[0].instr);
    end
`ifdef FETCH_MISALIGN_EN
    chk("fault", 32'(fault), 32'(m_fault));
    s_fault = fault;
`endif
    s_req = req; s_valid = ivalid; s_pc = ipc;
    if (ivalid) valid_seen++;
    @(posedge clk);
    if (exp_q.size() > 0 && ready && !redirect) begin
      dl_pc.push_back(exp_q[0].pc);
      dl_cyc.push_back(cyc);
      void'(exp_q.pop_front());
    end
    if (rvalid) begin
      r = mem_q.pop_front();
      if (r.epoch == epoch && !redirect) exp_q.push_back('{r.addr, data_of(r.addr)});
    end
    if (exp_req && gnt) begin
      mem_q.push_back('{exp_addr, epoch, cyc});
      req_log.push_back(exp_addr);
      grants++;
      exp_addr += 32'd4;
    end
    if (redirect) begin
      epoch++;
      exp_q.delete();
      exp_addr = redirect_pc & ~32'h3;
`ifdef FETCH_MISALIGN_EN
      halted  = (redirect_pc[1:0] != 2'b00);
      m_fault = halted;
`endif
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    gnt = 0; rvalid = 0; ready = 0; redirect = 0; redirect_pc = 0; rdata = 0;
    set_knobs(0, 0, 0, 0);

    // Streaming with single-cycle memory latency
    do_reset();
    set_knobs(100, 100, 100, 0);
    run(14);
    chk("t1_count", 32'(dl_pc.size() >= 4), 32'd1);
    if (dl_pc.size() >= 4) begin
      chk("t1_pc0", dl_pc[0], 32'h0);
      chk("t1_pc1", dl_pc[1], 32'h4);
      chk("t1_pc2", dl_pc[2], 32'h8);
      chk("t1_pc3", dl_pc[3], 32'hC);
      chk("t1_cyc0", 32'(dl_cyc[0]), 32'd2);
      chk("t1_cyc1", 32'(dl_cyc[1]), 32'd3);
    end

    // Back-pressure: credits stop at DEPTH grants
    do_reset();
    set_knobs(100, 100, 0, 0);
    run(8);
    chk("t2_grants", 32'(grants), 32'd2);
    chk("t2_req", 32'(s_req), 32'd0);
    chk("t2_valid", 32'(s_valid), 32'd1);
    chk("t2_head", s_pc, 32'h0);
    set_knobs(100, 100, 100, 0);
    run(1);
    chk("t2_pop", 32'(dl_pc.size()), 32'd1);
    if (dl_pc.size() >= 1) chk("t2_pop_pc", dl_pc[0], 32'h0);

    // Redirect with two requests outstanding
    do_reset();
    set_knobs(100, 0, 100, 0);
    run(3);
    force_redir = 1; force_pc = 32'h100;
    run(1);
    set_knobs(100, 100, 100, 0);
    run(2);
    chk("t3_grants", 32'(grants), 32'd2);
    run(1);
    chk("t3_no_valid", 32'(valid_seen), 32'd0);
    run(6);
    chk("t3_count", 32'(dl_pc.size() >= 1), 32'd1);
    if (dl_pc.size() >= 1) chk("t3_first_pc", dl_pc[0], 32'h100);

    // Redirect coinciding with rvalid and gnt
    do_reset();
    set_knobs(100, 100, 100, 0);
    run(2);
    force_redir = 1; force_pc = 32'h40;
    run(8);
    chk("t4_count", 32'(dl_pc.size() >= 1), 32'd1);
    if (dl_pc.size() >= 1) chk("t4_first_pc", dl_pc[0], 32'h40);

    // Address wrap at the top of the space
    do_reset();
    set_knobs(100, 100, 100, 0);
    force_redir = 1; force_pc = 32'hFFFF_FFFC;
    run(4);
    chk("t5_count", 32'(req_log.size() >= 2), 32'd1);
    if (req_log.size() >= 2) begin
      chk("t5_addr0", req_log[0], 32'hFFFF_FFFC);
      chk("t5_addr1", req_log[1], 32'h0);
    end

`ifdef FETCH_MISALIGN_EN
    // Misaligned redirect halts; an aligned redirect recovers
    do_reset();
    set_knobs(100, 100, 100, 0);
    run(3);
    force_redir = 1; force_pc = 32'h102;
    run(4);
    chk("t6_fault", 32'(s_fault), 32'd1);
    chk("t6_req", 32'(s_req), 32'd0);
    dl_pc.delete();
    force_redir = 1; force_pc = 32'h200;
    run(8);
    chk("t6_fault_clr", 32'(s_fault), 32'd0);
    chk("t6_count", 32'(dl_pc.size() >= 1), 32'd1);
    if (dl_pc.size() >= 1) chk("t6_first_pc", dl_pc[0], 32'h200);
`endif

    // Randomized traffic, including redirects, wraps and back-pressure
    for (int round = 0; round < 6; round++) begin
      do_reset();
      set_knobs($urandom_range(100, 30), $urandom_range(100, 20),
                $urandom_range(100, 20), $urandom_range(10, 0));
      run(400);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
